// File: rtl/hamming7_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit positions, word types and the
// syndrome equation used by the decoder.
package hamming7_pkg;

  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_D1 = 3;
  localparam int unsigned POS_P3 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;
  localparam int unsigned POS_D4 = 7;

  typedef logic [6:0] code7_t;
  typedef logic [3:0] data4_t;

  // Bit k-1 of the codeword holds position k.
  function automatic logic [2:0] syndrome_of(input code7_t c);
    logic s1;
    logic s2;
    logic s3;
    s1 = c[POS_P1-1] ^ c[POS_D1-1] ^ c[POS_D2-1] ^ c[POS_D4-1];
    s2 = c[POS_P2-1] ^ c[POS_D1-1] ^ c[POS_D3-1] ^ c[POS_D4-1];
    s3 = c[POS_P3-1] ^ c[POS_D2-1] ^ c[POS_D3-1] ^ c[POS_D4-1];
    return {s3, s2, s1};
  endfunction

endpackage

// File: rtl/hamming7_syndrome.sv
// Combinational Hamming(7,4) syndrome and single-error correction; the
// syndrome names the flipped position directly (0 = clean).
module hamming7_syndrome
  import hamming7_pkg::*;
(
  input  code7_t     code_i,
  output logic [2:0] syndrome_o,
  output data4_t     data_o
);

  logic [2:0] syn_s;
  code7_t     fixed_s;

  // Flip the located bit, then pull the four data positions out.
  always_comb begin
    syn_s   = syndrome_of(code_i);
    fixed_s = code_i;
    if (syn_s != 3'd0) begin
      fixed_s = code_i ^ (7'd1 << (syn_s - 3'd1));
    end else begin
      fixed_s = code_i;
    end
    syndrome_o = syn_s;
    data_o     = {fixed_s[POS_D4-1], fixed_s[POS_D3-1],
                  fixed_s[POS_D2-1], fixed_s[POS_D1-1]};
  end

endmodule

// File: rtl/hamming7_decoder.sv
// Two-stage valid/ready Hamming(7,4) decoder: S1 captures the codeword, S2
// holds the corrected data and syndrome; saturating frame/correction counters.
module hamming7_decoder
  import hamming7_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [6:0]       code_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       err_pos,
  output logic             err_flag,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  code7_t           s1_code_q, s1_code_d;
  logic             s2_valid_q, s2_valid_d;
  data4_t           s2_data_q, s2_data_d;
  logic [2:0]       s2_pos_q, s2_pos_d;
  logic             s2_flag_q, s2_flag_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] corr_q, corr_d;

  logic       s2_load_s;
  logic       s1_load_s;
  logic       accept_s;
  logic       xfer_s;
  logic [2:0] syn_s;
  data4_t     fix_data_s;

  hamming7_syndrome u_syndrome (
    .code_i     (s1_code_q),
    .syndrome_o (syn_s),
    .data_o     (fix_data_s)
  );

  // Pipeline advance: S2 frees up on a transfer, S1 may follow into it.
  always_comb begin
    s2_load_s  = !s2_valid_q || out_ready;
    s1_load_s  = !s1_valid_q || s2_load_s;
    accept_s   = in_valid && s1_load_s;
    xfer_s     = s2_valid_q && out_ready;

    s1_valid_d = s1_load_s ? accept_s : s1_valid_q;
    s1_code_d  = accept_s ? code_in : s1_code_q;

    s2_valid_d = s2_load_s ? s1_valid_q : s2_valid_q;
    if (s2_load_s && s1_valid_q) begin
      s2_data_d = fix_data_s;
      s2_pos_d  = syn_s;
      s2_flag_d = (syn_s != 3'd0);
    end else begin
      s2_data_d = s2_data_q;
      s2_pos_d  = s2_pos_q;
      s2_flag_d = s2_flag_q;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_comb begin
    frame_d = frame_q;
    corr_d  = corr_q;
    if (cnt_clear) begin
      frame_d = '0;
      corr_d  = '0;
    end else if (xfer_s) begin
      frame_d = (frame_q != CNT_MAX) ? frame_q + CNT_ONE : frame_q;
      corr_d  = (s2_flag_q && corr_q != CNT_MAX) ? corr_q + CNT_ONE : corr_q;
    end else begin
      frame_d = frame_q;
      corr_d  = corr_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= 7'd0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 4'd0;
      s2_pos_q   <= 3'd0;
      s2_flag_q  <= 1'b0;
      frame_q    <= '0;
      corr_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_pos_q   <= s2_pos_d;
      s2_flag_q  <= s2_flag_d;
      frame_q    <= frame_d;
      corr_q     <= corr_d;
    end
  end

  assign in_ready  = s1_load_s;
  assign out_valid = s2_valid_q;
  assign data_out  = s2_data_q;
  assign err_pos   = s2_pos_q;
  assign err_flag  = s2_flag_q;
  assign frame_cnt = frame_q;
  assign corr_cnt  = corr_q;

endmodule

// File: tb/tb_hamming7_decoder.sv
// Self-checking bench for hamming7_decoder: directed vectors, hand sequences
// for backpressure/saturation/reset, and a random stream against a model.
module tb_hamming7_decoder;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [6:0]  code_in;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clear;

  logic        in_ready, err_flag, out_valid;
  logic [3:0]  data_out;
  logic [2:0]  err_pos;
  logic [15:0] frame_cnt, corr_cnt;

  logic        s_in_ready, s_err_flag, s_out_valid;
  logic [3:0]  s_data_out;
  logic [2:0]  s_err_pos;
  logic [1:0]  s_frame_cnt, s_corr_cnt;

  hamming7_decoder #(.CNT_W(16)) u_dut (
    .clock(clock), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .err_pos(err_pos),
    .err_flag(err_flag), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clear(cnt_clear), .frame_cnt(frame_cnt), .corr_cnt(corr_cnt)
  );

  hamming7_decoder #(.CNT_W(2)) u_sat (
    .clock(clock), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
    .in_ready(s_in_ready), .data_out(s_data_out), .err_pos(s_err_pos),
    .err_flag(s_err_flag), .out_valid(s_out_valid), .out_ready(out_ready),
    .cnt_clear(cnt_clear), .frame_cnt(s_frame_cnt), .corr_cnt(s_corr_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] data;
    logic [2:0] pos;
  } exp_t;

  typedef struct {
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] pos;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   m_frame = 0;
  int   m_corr = 0;
  int   acc_total = 0;
  bit   last_acc = 1'b0;
  bit   started = 1'b0;
  bit   have_prev = 1'b0;
  logic [3:0] prev_data;
  logic [2:0] prev_pos;
  logic       prev_flag;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  // Nearest-codeword decoding: the code is perfect, so exactly one codeword
  // lies within distance 1 of any 7-bit word.
  function automatic exp_t ref_decode(input logic [6:0] c);
    exp_t r;
    logic [6:0] diff;
    r.data = 4'd0;
    r.pos  = 3'd0;
    for (int d = 0; d < 16; d++) begin
      diff = c ^ encode(4'(d));
      if ($countones(diff) <= 1) begin
        r.data = 4'(d);
        for (int i = 0; i < 7; i++) if (diff[i]) r.pos = 3'(i + 1);
      end
    end
    return r;
  endfunction

  // Scoreboard and counter model, evaluated mid-cycle on the falling edge.
  always @(negedge clock) begin
    if (!started) begin
      last_acc = 1'b0;
    end else if (!rst_n) begin
      q.delete();
      m_frame = 0;
      m_corr = 0;
      have_prev = 1'b0;
      last_acc = 1'b0;
    end else begin
      chk("frame_cnt", int'(frame_cnt), m_frame);
      chk("corr_cnt", int'(corr_cnt), m_corr);
      chk("sat_frame_cnt", int'(s_frame_cnt), (m_frame > 3) ? 3 : m_frame);
      chk("sat_corr_cnt", int'(s_corr_cnt), (m_corr > 3) ? 3 : m_corr);
      if (have_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(data_out), int'(prev_data));
        chk("hold_pos", int'(err_pos), int'(prev_pos));
        chk("hold_flag", int'(err_flag), int'(prev_flag));
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
        q.push_back(ref_decode(code_in));
        acc_total++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", int'(data_out), int'(e.data));
          chk("sb_pos", int'(err_pos), int'(e.pos));
          chk("sb_flag", int'(err_flag), int'(e.pos != 3'd0));
          if (!cnt_clear) begin
            m_frame++;
            if (e.pos != 3'd0) m_corr++;
          end
        end
      end
      if (cnt_clear) begin
        m_frame = 0;
        m_corr = 0;
      end
      have_prev = out_valid && !out_ready;
      prev_data = data_out;
      prev_pos  = err_pos;
      prev_flag = err_flag;
    end
  end

  task automatic send(input logic [6:0] c);
    bit done;
    done = 1'b0;
    code_in  = c;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(posedge clock);
      #1;
      if (last_acc) done = 1'b1;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(posedge clock);
      #1;
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    chk("drain", int'(done), 1);
  endtask

  task automatic clear_cnt();
    @(posedge clock);
    #1 cnt_clear = 1'b1;
    @(posedge clock);
    #1 cnt_clear = 1'b0;
  endtask

  vec_t vecs[8];
  int   run, max_run;
  int   acc_base;
  exp_t e0;
  logic [6:0] bp_words[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7'h55, 4'hB, 3'd0};
    vecs[1] = '{7'h54, 4'hB, 3'd1};
    vecs[2] = '{7'h57, 4'hB, 3'd2};
    vecs[3] = '{7'h51, 4'hB, 3'd3};
    vecs[4] = '{7'h5D, 4'hB, 3'd4};
    vecs[5] = '{7'h45, 4'hB, 3'd5};
    vecs[6] = '{7'h75, 4'hB, 3'd6};
    vecs[7] = '{7'h15, 4'hB, 3'd7};

    rst_n = 1'b0; code_in = 7'd0; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    started = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_pos", int'(err_pos), 0);
    chk("rst_flag", int'(err_flag), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_frame", int'(frame_cnt), 0);

    // Directed vectors: clean word then each single-bit error, 2-edge latency.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].code);
      in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("vec_valid", int'(out_valid), 1);
      chk("vec_data", int'(data_out), int'(vecs[i].data));
      chk("vec_pos", int'(err_pos), int'(vecs[i].pos));
      chk("vec_flag", int'(err_flag), int'(vecs[i].pos != 3'd0));
      @(negedge clock);
      if (i == 0) begin
        chk("clean_frame", int'(frame_cnt), 1);
        chk("clean_corr", int'(corr_cnt), 0);
      end
    end
    chk("sweep_corr", int'(corr_cnt), 7);
    chk("sweep_frame", int'(frame_cnt), 8);

    // Backpressure: 4 words against a 5-cycle stall.
    clear_cnt();
    for (int i = 0; i < 4; i++) bp_words[i] = encode(4'(i * 5 + 1)) ^ 7'(i == 2 ? 7'h08 : 7'h00);
    e0 = ref_decode(bp_words[0]);
    out_ready = 1'b0;
    acc_base = acc_total;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp_words[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("bp_accepts", acc_total - acc_base, 2);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_head_data", int'(data_out), int'(e0.data));
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_frames", int'(frame_cnt), 4);

    // Throughput: 16 back-to-back words.
    clear_cnt();
    max_run = 0;
    run = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(7'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (26) begin
          @(negedge clock);
          run = out_valid ? run + 1 : 0;
          if (run > max_run) max_run = run;
        end
      end
    join
    drain();
    chk("tp_run", max_run, 16);
    chk("tp_frames", int'(frame_cnt), 16);

    // Saturation with the 2-bit instance, then clear against a transfer.
    clear_cnt();
    for (int i = 0; i < 5; i++) send(encode(4'($urandom)) ^ (7'd1 << (i % 7)));
    in_valid = 1'b0;
    drain();
    chk("sat_frame", int'(s_frame_cnt), 3);
    chk("sat_corr", int'(s_corr_cnt), 3);
    send(7'h45);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("clr_out_valid", int'(out_valid), 1);
    cnt_clear = 1'b1;
    @(posedge clock);
    #1 cnt_clear = 1'b0;
    chk("clr_frame", int'(frame_cnt), 0);
    chk("clr_corr", int'(corr_cnt), 0);
    chk("clr_sat_frame", int'(s_frame_cnt), 0);
    chk("clr_sat_corr", int'(s_corr_cnt), 0);

    // Random stream with random gaps and backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clock);
      #1;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(3) != 0);
        code_in  = 7'($urandom);
      end
      out_ready = ($urandom_range(2) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages full.
    send(7'h33);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    send(7'h45);
    send(7'h15);
    in_valid = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_frame", int'(frame_cnt), 0);
    chk("mid_rst_corr", int'(corr_cnt), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    run = 0;
    repeat (5) begin
      @(negedge clock);
      if (out_valid) run++;
    end
    chk("mid_rst_no_stale", run, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
